// File: rtl/op_mode_scheduler_if.sv
// ---------------------------------------------------------------------------
// op_mode_scheduler_if
// Handshake bundle between the controller (master) and op_mode_scheduler
// (slave), used for mode-switch requests.
//   req_valid     : master -> slave, a switch request is present
//   req_ready     : slave -> master, request accepted when valid && ready
//   req_mode      : master -> slave, requested mode (0 normal, 1 STM)
//   req_immediate : master -> slave, ignore req_time and switch on next boundary
//   req_time      : master -> slave, earliest SYS_TIME at which to switch
//   cancel        : master -> slave, abort a pending request
// ---------------------------------------------------------------------------
interface op_mode_scheduler_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_mode;
  logic        req_immediate;
  logic [63:0] req_time;
  logic        cancel;

  modport master (
    output req_valid,
    output req_mode,
    output req_immediate,
    output req_time,
    output cancel,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_mode,
    input  req_immediate,
    input  req_time,
    input  cancel,
    output req_ready
  );
endinterface : op_mode_scheduler_if

// File: rtl/op_mode_scheduler.sv
// ---------------------------------------------------------------------------
// op_mode_scheduler
// Sequences the normal/STM datapath select so that the duty/phase mux only
// changes on an ultrasound-period boundary of the system time. Timed requests
// let every device on a chain switch in the same period; a watchdog event
// forces normal mode immediately.
//
// Ports:
//   i_clk          : clk_l domain clock
//   i_reset_n      : synchronous, active-low reset
//   io_req         : request handshake (slave side of op_mode_scheduler_if)
//   i_sys_time     : synchronized system time, may step by more than 1/clk
//   i_wdt_assert   : watchdog fired, overrides everything
//   o_op_mode      : applied mode to the datapath mux (0 normal, 1 STM)
//   o_switch_pulse : one-cycle pulse in the cycle o_op_mode changes
//   o_busy         : a request is pending
//   o_late         : sticky, last accepted timed request was already due
//   o_forced       : watchdog override active
//   o_switch_count : number of applied mode changes, wraps
// ---------------------------------------------------------------------------
module op_mode_scheduler #(
  parameter int PERIOD_BITS = 12,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  op_mode_scheduler_if.slave   io_req,
  input  logic [63:0]          i_sys_time,
  input  logic                 i_wdt_assert,
  output logic                 o_op_mode,
  output logic                 o_switch_pulse,
  output logic                 o_busy,
  output logic                 o_late,
  output logic                 o_forced,
  output logic [CNT_WIDTH-1:0] o_switch_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TIME = 3'd1,
    ST_WAIT_BND  = 3'd2,
    ST_APPLY     = 3'd3,
    ST_FORCE     = 3'd4
  } state_t;

  // Registered state
  state_t                 r_state;
  logic [PERIOD_BITS-1:0] r_prev_lsb;
  logic                   r_bnd_en;
  logic                   r_mode;
  logic [63:0]            r_time;
  logic                   r_op_mode;
  logic                   r_pulse;
  logic                   r_busy;
  logic                   r_late;
  logic                   r_forced;
  logic                   r_req_ready;
  logic [CNT_WIDTH-1:0]   r_count;

  // Combinational helpers
  logic [PERIOD_BITS-1:0] w_cur_lsb;
  logic                   w_bnd;
  logic                   w_accept;
  logic                   w_time_reached;
  logic                   w_req_due;
  state_t                 w_next_state;
  logic                   w_new_mode;
  logic                   w_change;

  // A boundary is a wrap of the period LSBs; comparing against the previous
  // sample tolerates multi-tick steps. r_bnd_en masks the first post-reset
  // cycle, where r_prev_lsb does not hold a real sample yet.
  assign w_cur_lsb      = i_sys_time[PERIOD_BITS-1:0];
  assign w_bnd          = r_bnd_en && (w_cur_lsb < r_prev_lsb);
  // r_req_ready is only ever high while in IDLE, so it qualifies acceptance.
  assign w_accept       = io_req.req_valid && r_req_ready;
  assign w_time_reached = (i_sys_time >= r_time);
  assign w_req_due      = (io_req.req_time <= i_sys_time);

  // Next-state and mode-change decode; watchdog overrides every state.
  always_comb begin
    w_next_state = r_state;
    w_new_mode   = r_op_mode;
    w_change     = 1'b0;
    if (i_wdt_assert) begin
      w_next_state = ST_FORCE;
      if (r_op_mode) begin
        w_new_mode = 1'b0;
        w_change   = 1'b1;
      end else begin
        w_change   = 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          // CANCEL is ignored in IDLE, so a simultaneous request is accepted.
          if (w_accept) begin
            w_next_state = io_req.req_immediate ? ST_WAIT_BND : ST_WAIT_TIME;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_WAIT_TIME: begin
          if (io_req.cancel) begin
            w_next_state = ST_IDLE;
          end else if (w_time_reached) begin
            // Any boundary in this same cycle is not used: WAIT_BND only
            // looks at boundaries from the next cycle on.
            w_next_state = ST_WAIT_BND;
          end else begin
            w_next_state = ST_WAIT_TIME;
          end
        end
        ST_WAIT_BND: begin
          if (io_req.cancel) begin
            w_next_state = ST_IDLE;
          end else if (w_bnd) begin
            w_next_state = ST_APPLY;
          end else begin
            w_next_state = ST_WAIT_BND;
          end
        end
        ST_APPLY: begin
          w_next_state = ST_IDLE;
          if (r_mode != r_op_mode) begin
            w_new_mode = r_mode;
            w_change   = 1'b1;
          end else begin
            w_change   = 1'b0;
          end
        end
        ST_FORCE: begin
          // Reaching here means the watchdog has just deasserted.
          w_next_state = ST_IDLE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Period-boundary tracker: previous LSB sample and post-reset mask.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_prev_lsb <= {PERIOD_BITS{1'b0}};
      r_bnd_en   <= 1'b0;
    end else begin
      r_prev_lsb <= w_cur_lsb;
      r_bnd_en   <= 1'b1;
    end
  end

  // Request capture and the sticky LATE flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_mode <= 1'b0;
      r_time <= 64'd0;
      r_late <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode <= io_req.req_mode;
        r_time <= io_req.req_time;
      end
      // Only a timed request that is really taken updates LATE; a request
      // swallowed by the watchdog in the same cycle leaves it alone.
      if (w_next_state == ST_WAIT_TIME && r_state == ST_IDLE) begin
        r_late <= w_req_due;
      end
    end
  end

  // Applied mode, switch pulse and switch counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_op_mode <= 1'b0;
      r_pulse   <= 1'b0;
      r_count   <= {CNT_WIDTH{1'b0}};
    end else begin
      r_op_mode <= w_new_mode;
      r_pulse   <= w_change;
      if (w_change) begin
        r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Status flags, all derived from the state being entered.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_busy      <= 1'b0;
      r_forced    <= 1'b0;
      r_req_ready <= 1'b0;
    end else begin
      r_busy      <= (w_next_state == ST_WAIT_TIME) ||
                     (w_next_state == ST_WAIT_BND)  ||
                     (w_next_state == ST_APPLY);
      r_forced    <= (w_next_state == ST_FORCE);
      r_req_ready <= (w_next_state == ST_IDLE);
    end
  end

  assign io_req.req_ready = r_req_ready;
  assign o_op_mode        = r_op_mode;
  assign o_switch_pulse   = r_pulse;
  assign o_busy           = r_busy;
  assign o_late           = r_late;
  assign o_forced         = r_forced;
  assign o_switch_count   = r_count;

endmodule : op_mode_scheduler

// File: tb/tb_op_mode_scheduler.sv
// ---------------------------------------------------------------------------
// tb_op_mode_scheduler
// Directed bench for op_mode_scheduler: a per-cycle vector table followed by
// hand-written multi-cycle sequences. A second instance with a 3-bit counter
// shares the same stimulus so the counter wrap can be seen quickly.
// ---------------------------------------------------------------------------
module tb_op_mode_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] sys_time;
  logic        wdt;

  logic        op, pulse, busy, late, forced;
  logic [15:0] cnt;
  logic        op_n, pulse_n, busy_n, late_n, forced_n;
  logic [2:0]  cnt_n;

  op_mode_scheduler_if bus ();
  op_mode_scheduler_if bus_n ();

  assign bus_n.req_valid     = bus.req_valid;
  assign bus_n.req_mode      = bus.req_mode;
  assign bus_n.req_immediate = bus.req_immediate;
  assign bus_n.req_time      = bus.req_time;
  assign bus_n.cancel        = bus.cancel;

  always #5 clk = ~clk;

  op_mode_scheduler #(.PERIOD_BITS(12), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .io_req(bus.slave),
    .i_sys_time(sys_time), .i_wdt_assert(wdt),
    .o_op_mode(op), .o_switch_pulse(pulse), .o_busy(busy),
    .o_late(late), .o_forced(forced), .o_switch_count(cnt)
  );

  op_mode_scheduler #(.PERIOD_BITS(12), .CNT_WIDTH(3)) dut_n (
    .i_clk(clk), .i_reset_n(rst_n), .io_req(bus_n.slave),
    .i_sys_time(sys_time), .i_wdt_assert(wdt),
    .o_op_mode(op_n), .o_switch_pulse(pulse_n), .o_busy(busy_n),
    .o_late(late_n), .o_forced(forced_n), .o_switch_count(cnt_n)
  );

  typedef struct packed {
    logic        rst_n;
    logic [63:0] t;
    logic        valid, mode, imm, cancel, wdt;
    logic        e_op, e_pulse, e_busy, e_ready, e_forced, e_late;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [0:NV-1];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] cur_t;
  localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {63'd0, act}, {63'd0, exp});
  endtask

  // One clock: drive SYS_TIME, wait for the edge, settle before sampling.
  task automatic cyc(input logic [63:0] t);
    sys_time = t;
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req(input logic m, input logic imm, input logic [63:0] rt);
    bus.req_valid     = 1'b1;
    bus.req_mode      = m;
    bus.req_immediate = imm;
    bus.req_time      = rt;
    cyc(cur_t);
    bus.req_valid     = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    cur_t = 64'd0;
    cyc(cur_t);
    chk1("rst op", op, 1'b0);
    chk1("rst ready", bus.req_ready, 1'b0);
    chk("rst cnt", {48'd0, cnt}, 64'd0);
    rst_n = 1'b1;
    cyc(cur_t);
  endtask

  // Advance time by step per cycle; report the time of the first cycle with
  // OP_MODE high and the number of switch pulses seen.
  task automatic run_watch(input logic [63:0] step, input int budget,
                           output logic [63:0] rise_t, output int pulses);
    rise_t = NONE;
    pulses = 0;
    for (int i = 0; i < budget; i++) begin
      cur_t = cur_t + step;
      cyc(cur_t);
      if (pulse) pulses++;
      if (op && rise_t == NONE) rise_t = cur_t;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rise_t;
    int          pulses;
    int          total;
    int          cross_i, rise_i;
    logic        busy_ok;

    //          rst  t           v     m     i     c     w     op    pls   busy  rdy   frc   late  cnt
    tbl[0]  = '{1'b0, 64'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 64'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 64'h0C00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 64'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 64'h1400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 64'h1800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 64'h1C00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[7]  = '{1'b1, 64'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[8]  = '{1'b1, 64'h2400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[9]  = '{1'b1, 64'h2800, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[10] = '{1'b1, 64'h2C00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[11] = '{1'b1, 64'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[12] = '{1'b1, 64'h3400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
    tbl[13] = '{1'b1, 64'h3800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
    tbl[14] = '{1'b1, 64'h3C00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[15] = '{1'b1, 64'h4000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[16] = '{1'b1, 64'h4400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[17] = '{1'b1, 64'h4800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[18] = '{1'b1, 64'h4C00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[19] = '{1'b1, 64'h5000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[20] = '{1'b1, 64'h5400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3};

    rst_n             = 1'b0;
    sys_time          = 64'd0;
    wdt               = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_mode      = 1'b0;
    bus.req_immediate = 1'b0;
    bus.req_time      = 64'd0;
    bus.cancel        = 1'b0;
    cur_t             = 64'd0;

    // ---- table: reset, immediate switch, same-mode, cancel, watchdog ----
    for (int i = 0; i < NV; i++) begin
      rst_n             = tbl[i].rst_n;
      bus.req_valid     = tbl[i].valid;
      bus.req_mode      = tbl[i].mode;
      bus.req_immediate = tbl[i].imm;
      bus.req_time      = 64'd0;
      bus.cancel        = tbl[i].cancel;
      wdt               = tbl[i].wdt;
      cyc(tbl[i].t);
      chk1($sformatf("v%0d op", i), op, tbl[i].e_op);
      chk1($sformatf("v%0d pulse", i), pulse, tbl[i].e_pulse);
      chk1($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
      chk1($sformatf("v%0d ready", i), bus.req_ready, tbl[i].e_ready);
      chk1($sformatf("v%0d forced", i), forced, tbl[i].e_forced);
      chk1($sformatf("v%0d late", i), late, tbl[i].e_late);
      chk($sformatf("v%0d cnt", i), {48'd0, cnt}, {48'd0, tbl[i].e_cnt});
      chk($sformatf("v%0d cnt3", i), {61'd0, cnt_n}, {61'd0, tbl[i].e_cnt[2:0]});
    end
    bus.cancel = 1'b0;
    wdt        = 1'b0;

    // ---- immediate request, SYS_TIME +2 per cycle from 0x0F00 ----
    reset_dut();
    cur_t = 64'h0F00;
    accept_req(1'b1, 1'b1, 64'd0);
    chk1("imm busy", busy, 1'b1);
    cross_i = -1;
    rise_i  = -1;
    pulses  = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cur_t = cur_t + 64'd2;
      cyc(cur_t);
      if (cur_t == 64'h1000) cross_i = i;
      if (pulse) pulses++;
      if (op && rise_i < 0) rise_i = i;
      if (!op && !busy) busy_ok = 1'b0;
    end
    chk("imm cross", 64'(cross_i), 64'd127);
    chk("imm rise", 64'(rise_i), 64'(cross_i + 1));
    chk("imm pulses", 64'(pulses), 64'd1);
    chk("imm cnt", {48'd0, cnt}, 64'd1);
    chk1("imm busy held", busy_ok, 1'b1);

    // ---- late timed request ----
    reset_dut();
    cur_t = 64'h3000;
    accept_req(1'b1, 1'b0, 64'h0800);
    chk1("late flag", late, 1'b1);
    run_watch(64'h100, 32, rise_t, pulses);
    chk("late rise", rise_t, 64'h4100);
    chk("late pulses", 64'(pulses), 64'd1);
    chk1("late sticky", late, 1'b1);
    accept_req(1'b0, 1'b0, cur_t + 64'h800);
    chk1("late cleared", late, 1'b0);

    // ---- on-time timed request ----
    reset_dut();
    cur_t = 64'h1000;
    accept_req(1'b1, 1'b0, 64'h5800);
    chk1("timed late", late, 1'b0);
    chk1("timed busy", busy, 1'b1);
    run_watch(64'h100, 96, rise_t, pulses);
    chk("timed rise", rise_t, 64'h6100);
    chk("timed pulses", 64'(pulses), 64'd1);

    // ---- cancel while waiting for time ----
    reset_dut();
    cur_t = 64'h1000;
    accept_req(1'b1, 1'b0, 64'h5800);
    run_watch(64'h100, 16, rise_t, pulses);
    bus.cancel = 1'b1;
    cur_t = 64'h2100;
    cyc(cur_t);
    bus.cancel = 1'b0;
    chk1("cancel busy", busy, 1'b0);
    chk1("cancel ready", bus.req_ready, 1'b1);
    run_watch(64'h100, 72, rise_t, pulses);
    chk("cancel rise", rise_t, NONE);
    chk("cancel pulses", 64'(pulses), 64'd0);

    // ---- watchdog with OP_MODE=1 and a pending request ----
    reset_dut();
    cur_t = 64'h0400;
    accept_req(1'b1, 1'b1, 64'd0);
    run_watch(64'h400, 8, rise_t, pulses);
    chk("wdt pre rise", rise_t, 64'h1400);
    accept_req(1'b1, 1'b0, cur_t + 64'h800);
    chk1("wdt pre busy", busy, 1'b1);
    wdt = 1'b1;
    cur_t = cur_t + 64'h400;
    cyc(cur_t);
    chk1("wdt op", op, 1'b0);
    chk1("wdt pulse", pulse, 1'b1);
    chk1("wdt forced", forced, 1'b1);
    chk1("wdt ready", bus.req_ready, 1'b0);
    chk1("wdt busy", busy, 1'b0);
    chk("wdt cnt", {48'd0, cnt}, 64'd2);
    run_watch(64'h400, 4, rise_t, pulses);
    chk1("wdt held forced", forced, 1'b1);
    chk1("wdt held ready", bus.req_ready, 1'b0);
    wdt = 1'b0;
    cur_t = cur_t + 64'h400;
    cyc(cur_t);
    chk1("wdt exit forced", forced, 1'b0);
    chk1("wdt exit ready", bus.req_ready, 1'b1);
    run_watch(64'h400, 12, rise_t, pulses);
    chk("wdt discard pulses", 64'(pulses), 64'd0);
    chk1("wdt discard op", op, 1'b0);

    // ---- reset while waiting for a boundary ----
    cur_t = cur_t + 64'h400;
    accept_req(1'b1, 1'b1, 64'd0);
    chk1("rstmid busy", busy, 1'b1);
    rst_n = 1'b0;
    cyc(cur_t);
    chk1("rstmid op", op, 1'b0);
    chk1("rstmid busy0", busy, 1'b0);
    chk1("rstmid forced", forced, 1'b0);
    chk1("rstmid ready", bus.req_ready, 1'b0);
    chk("rstmid cnt", {48'd0, cnt}, 64'd0);
    rst_n = 1'b1;
    cyc(cur_t);
    run_watch(64'h400, 8, rise_t, pulses);
    chk("rstmid pulses", 64'(pulses), 64'd0);

    // ---- counter wrap on the 3-bit instance ----
    total = 0;
    for (int k = 1; k <= 8; k++) begin
      accept_req((k % 2 == 1) ? 1'b1 : 1'b0, 1'b1, 64'd0);
      run_watch(64'h400, 8, rise_t, pulses);
      total += pulses;
      if (k == 7) chk("wrap cnt3 at 7", {61'd0, cnt_n}, 64'd7);
    end
    chk("wrap pulses", 64'(total), 64'd8);
    chk("wrap cnt", {48'd0, cnt}, 64'd8);
    chk("wrap cnt3", {61'd0, cnt_n}, 64'd0);
    chk1("wrap op3", op_n, 1'b0);
    chk1("wrap busy3", busy_n, 1'b0);
    chk1("wrap pulse3", pulse_n, 1'b0);
    chk1("wrap late3", late_n, 1'b0);
    chk1("wrap forced3", forced_n, 1'b0);
    chk1("wrap ready3", bus_n.req_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_op_mode_scheduler
